// File: rtl/demux8_dispatch_pkg.sv
// Shared definitions for the 8-way demultiplexing dispatcher: channel count,
// select width, slot state encoding and the select decoder.
package demux8_dispatch_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  // One-hot decode of a channel index; the top uses it to steer in_valid.
  function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] one;
    one = {{(NUM_CH-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage

// File: rtl/demux8_dispatch_slot.sv
// demux_slot: one-entry holding buffer with valid/ready on both sides.
// Optional delivery counter is built when DEMUX8_CNT_EN is defined.
module demux_slot
  import demux8_dispatch_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef DEMUX8_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DEMUX8_CNT_EN
  , output logic [CNT_W-1:0] out_cnt
`endif
);

  slot_state_t      state_q;
  slot_state_t      state_d;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A full slot still accepts when it drains in the same cycle, which keeps
  // one word per cycle flowing through a channel.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    in_fire   = 1'b0;
    out_fire  = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready = 1'b1;
        in_fire  = in_valid;
        if (in_fire) begin
          state_d = FULL;
        end
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        out_fire  = out_ready;
        in_fire   = in_valid && out_ready;
        if (out_fire && !in_fire) begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
    end else if (in_fire) begin
      data_q <= in_data;
    end
  end

  assign out_data = data_q;

`ifdef DEMUX8_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (out_fire) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_cnt = cnt_q;
`endif

endmodule

// File: rtl/demux8_dispatch.sv
// demux8_dispatch: routes one payload per cycle to one of 8 independent
// one-entry channel slots. Define DEMUX8_CNT_EN to add per-channel counters.
module demux8_dispatch
  import demux8_dispatch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [WIDTH-1:0]        in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data
`ifdef DEMUX8_CNT_EN
  , output logic [NUM_CH*CNT_W-1:0] out_cnt
`endif
);

  logic [NUM_CH-1:0] sel_onehot;
  logic [NUM_CH-1:0] slot_in_valid;
  logic [NUM_CH-1:0] slot_in_ready;

  // in_ready depends only on the addressed slot, never on in_valid.
  assign sel_onehot    = sel_decode(in_sel);
  assign slot_in_valid = sel_onehot & {NUM_CH{in_valid}};
  assign in_ready      = slot_in_ready[in_sel];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
`ifdef DEMUX8_CNT_EN
      , .CNT_W (CNT_W)
`endif
    ) u_slot (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (slot_in_valid[i]),
      .in_ready  (slot_in_ready[i]),
      .in_data   (in_data),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .out_data  (out_data[i*WIDTH +: WIDTH])
`ifdef DEMUX8_CNT_EN
      , .out_cnt (out_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

`ifndef DEMUX8_CNT_EN
  // CNT_W stays a parameter in the counter-less build so overrides remain valid.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_demux8_dispatch.sv
// Self-checking bench for demux8_dispatch: directed scenarios plus a random
// run against a per-channel queue model (counters checked with DEMUX8_CNT_EN).
module tb_demux8_dispatch;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int NCH   = 8;

  logic               clk = 1'b0;
  logic               resetn;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_sel;
  logic [WIDTH-1:0]   in_data;
  logic [NCH-1:0]     out_valid;
  logic [NCH-1:0]     out_ready;
  logic [NCH*WIDTH-1:0] out_data;
`ifdef DEMUX8_CNT_EN
  logic [NCH*CNT_W-1:0] out_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference: each channel is a queue of capacity one plus a delivery count.
  logic [WIDTH-1:0] mq [NCH][$];
  int               mcnt [NCH];

  always #5 clk = ~clk;

  demux8_dispatch #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX8_CNT_EN
    , .out_cnt (out_cnt)
`endif
  );

  task automatic clear_model();
    for (int i = 0; i < NCH; i++) begin
      mq[i].delete();
      mcnt[i] = 0;
    end
  endtask

  function automatic logic model_ready();
    return (mq[in_sel].size() == 0) || out_ready[in_sel];
  endfunction

  function automatic logic [NCH-1:0] model_valid();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (mq[i].size() != 0);
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] ch_data(input int i);
    return out_data[i*WIDTH +: WIDTH];
  endfunction

  task automatic drive(input logic v, input logic [2:0] sel,
                       input logic [WIDTH-1:0] d, input logic [NCH-1:0] rdy);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge.
  task automatic tick();
    logic acc;
    @(posedge clk);
    if (!resetn) begin
      clear_model();
    end else begin
      acc = in_valid && model_ready();
      for (int i = 0; i < NCH; i++) begin
        if (mq[i].size() != 0 && out_ready[i]) begin
          void'(mq[i].pop_front());
          mcnt[i] = (mcnt[i] + 1) % (1 << CNT_W);
        end
      end
      if (acc) mq[in_sel].push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b0, 3'd0, '0, '0);
    #1;
    checks++;
    if (out_valid !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %h want 00", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data);
    end
`ifdef DEMUX8_CNT_EN
    checks++;
    if (out_cnt !== '0) begin
      errors++; $display("[TB] FAIL reset_out_cnt: got %h want 0", out_cnt);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    clear_model();
  endtask

  task automatic test_single();
    drive(1'b1, 3'd5, 32'hDEADBEEF, 8'hFF);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL single_in_ready: got %b want 1", in_ready);
    end
    tick();
    drive(1'b0, 3'd0, '0, 8'hFF);
    checks++;
    if (out_valid !== 8'h20) begin
      errors++; $display("[TB] FAIL single_out_valid: got %h want 20", out_valid);
    end
    checks++;
    if (ch_data(5) !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL single_out_data: got %h want deadbeef", ch_data(5));
    end
    tick();
    checks++;
    if (out_valid !== 8'h00) begin
      errors++; $display("[TB] FAIL single_one_cycle: got %h want 00", out_valid);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 3'd3, 32'hA1A1_0001, 8'hF7);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_first_ready: got %b want 1", in_ready);
    end
    tick();
    drive(1'b1, 3'd3, 32'hA2A2_0002, 8'hF7);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_second_ready: got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 8'h08 || ch_data(3) !== 32'hA1A1_0001) begin
      errors++;
      $display("[TB] FAIL stall_hold: got valid=%h data=%h want valid=08 data=a1a10001",
               out_valid, ch_data(3));
    end
    drive(1'b1, 3'd3, 32'hA2A2_0002, 8'hFF);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_release_ready: got %b want 1", in_ready);
    end
    tick();
    drive(1'b0, 3'd0, '0, 8'hF7);
    checks++;
    if (out_valid !== 8'h08 || ch_data(3) !== 32'hA2A2_0002) begin
      errors++;
      $display("[TB] FAIL stall_second_payload: got valid=%h data=%h want valid=08 data=a2a20002",
               out_valid, ch_data(3));
    end
  endtask

  // Channel 3 is left full and stalled by test_stall.
  task automatic test_independent();
    logic [WIDTH-1:0] d;
    for (int ch = 0; ch < NCH; ch++) begin
      if (ch == 3) continue;
      d = 32'hC0DE_0000 + WIDTH'(ch);
      drive(1'b1, 3'(ch), d, 8'hF7);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL indep_ready_ch%0d: got %b want 1", ch, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== (8'h08 | (8'h01 << ch)) || ch_data(ch) !== d) begin
        errors++;
        $display("[TB] FAIL indep_out_ch%0d: got valid=%h data=%h want valid=%h data=%h",
                 ch, out_valid, ch_data(ch), 8'h08 | (8'h01 << ch), d);
      end
    end
    drive(1'b0, 3'd0, '0, 8'hFF);
    tick();
    checks++;
    if (out_valid !== 8'h00) begin
      errors++; $display("[TB] FAIL indep_drain: got %h want 00", out_valid);
    end
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] d;
    for (int k = 0; k < 100; k++) begin
      d = 32'h7000_0000 + WIDTH'(k * 3);
      drive(1'b1, 3'd7, d, 8'hFF);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL stream_ready_%0d: got %b want 1", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 8'h80 || ch_data(7) !== d) begin
        errors++;
        $display("[TB] FAIL stream_word_%0d: got valid=%h data=%h want valid=80 data=%h",
                 k, out_valid, ch_data(7), d);
      end
    end
    drive(1'b0, 3'd0, '0, 8'hFF);
    tick();
    checks++;
    if (out_valid !== 8'h00) begin
      errors++; $display("[TB] FAIL stream_end: got %h want 00", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 3'd1, 32'h1111_1111, 8'h00);
    tick();
    drive(1'b1, 3'd2, 32'h2222_2222, 8'h00);
    tick();
    drive(1'b0, 3'd2, '0, 8'h00);
    checks++;
    if (out_valid !== 8'h06) begin
      errors++; $display("[TB] FAIL midrst_filled: got %h want 06", out_valid);
    end
    #3;
    resetn = 1'b0;
    #1;
    clear_model();
    checks++;
    if (out_valid !== 8'h00) begin
      errors++; $display("[TB] FAIL midrst_valid_drop: got %h want 00", out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    out_ready = 8'hFF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_ready: got %b want 1", in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (out_valid !== 8'h00) begin
        errors++; $display("[TB] FAIL midrst_stale_%0d: got %h want 00", k, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] rdy;
    logic [NCH-1:0] exp_v;
    logic           exp_r;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NCH; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), $urandom(), rdy);
      #1;
      exp_r = model_ready();
      checks++;
      if (in_ready !== exp_r) begin
        errors++; $display("[TB] FAIL rand_ready_%0d: got %b want %b", n, in_ready, exp_r);
      end
      tick();
      exp_v = model_valid();
      checks++;
      if (out_valid !== exp_v) begin
        errors++; $display("[TB] FAIL rand_valid_%0d: got %h want %h", n, out_valid, exp_v);
      end
      for (int i = 0; i < NCH; i++) begin
        if (exp_v[i]) begin
          checks++;
          if (ch_data(i) !== mq[i][0]) begin
            errors++;
            $display("[TB] FAIL rand_data_%0d_ch%0d: got %h want %h", n, i, ch_data(i), mq[i][0]);
          end
        end
`ifdef DEMUX8_CNT_EN
        checks++;
        if (out_cnt[i*CNT_W +: CNT_W] !== CNT_W'(mcnt[i])) begin
          errors++;
          $display("[TB] FAIL rand_cnt_%0d_ch%0d: got %0d want %0d",
                   n, i, out_cnt[i*CNT_W +: CNT_W], mcnt[i]);
        end
`endif
      end
    end
    drive(1'b0, 3'd0, '0, 8'hFF);
    tick();
  endtask

`ifdef DEMUX8_CNT_EN
  task automatic test_counter();
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    clear_model();
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 3'd0, WIDTH'(k), 8'hFF);
      tick();
    end
    drive(1'b0, 3'd0, '0, 8'hFF);
    tick();
    checks++;
    if (out_cnt[CNT_W-1:0] !== 4'd1) begin
      errors++; $display("[TB] FAIL cnt_wrap_ch0: got %0d want 1", out_cnt[CNT_W-1:0]);
    end
    checks++;
    if (out_cnt[NCH*CNT_W-1:CNT_W] !== '0) begin
      errors++; $display("[TB] FAIL cnt_others: got %h want 0", out_cnt[NCH*CNT_W-1:CNT_W]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_independent();
    test_stream();
    test_reset_mid();
    test_random();
`ifdef DEMUX8_CNT_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
